mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the load/store unit.
//   SZ_*              request size encodings carried on req_size
//   state_t           FSM state type of mem_access_unit
//   req_is_bad()      flags an illegal size or an access that is not
//                     naturally aligned (such requests bypass memory)
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_t;

  // True when the request must be answered with an error instead of a memory access.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane handling.
//   i_word       word read from memory
//   i_size       request size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_signed     sign-extend the extracted load value
//   i_lane       low two address bits (byte lane; bit 1 selects the half)
//   i_wdata      right-aligned store data
//   o_load_data  extracted and extended load value
//   o_merged     i_word with the store data written into the addressed lane
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // Load path: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_size)
      SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      SZ_WORD: o_load_data = i_word;
      default: o_load_data = 32'h0000_0000;
    endcase
  end

  // Store path: overwrite only the addressed lane, keep the other bytes.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_lane[1]) begin
          o_merged[31:16] = i_wdata[15:0];
        end else begin
          o_merged[15:0] = i_wdata[15:0];
        end
      end
      SZ_WORD: o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit in front of a 32-word memory
// with combinational read data. Stores are read-modify-write.
//   CLK, RST               clock, synchronous active-high reset
//   req_*                  request from execute stage (accepted when req_ready)
//   resp_valid/rdata/err   one-cycle completion with extended load data
//   mem_read/write/addr/wdata, mem_rdata   word-memory port
// Flow: IDLE -> ACCESS -> RESP (load), IDLE -> ACCESS -> WRITE -> RESP (store),
//       IDLE -> RESP (misaligned or illegal size).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [4:0]        mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;
  logic [31:0]         r_mem_wdata;
  logic                w_accept;
  logic                w_bad;
  logic                w_req_ready;
  logic                w_mem_read;
  logic                w_mem_write;
  logic [31:0]         w_load_data;
  logic [31:0]         w_merged;

  assign w_accept = req_valid & (r_state == IDLE);
  assign w_bad    = req_is_bad(req_size, req_addr[1:0]);

  mem_lane_align u_align (
    .i_word      (mem_rdata),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_lane      (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and memory/handshake strobes; strobes are gated by RST so a
  // reset landing in WRITE never commits the store.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (w_accept) begin
          w_next_state = w_bad ? RESP : ACCESS;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCESS: begin
        w_mem_read   = 1'b1;
        w_next_state = r_we ? WRITE : RESP;
      end
      WRITE: begin
        w_mem_write  = 1'b1;
        w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (RST) begin
      w_req_ready = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
    end else begin
      w_req_ready = w_req_ready;
    end
  end

  // Request latch, read-modify-write buffer and response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= 32'h0000_0000;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
    end else begin
      r_resp_valid <= (w_next_state == RESP);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we         <= req_we;
            r_size       <= req_size;
            r_signed     <= req_signed;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_resp_err   <= w_bad;
            r_resp_rdata <= 32'h0000_0000;
          end
        end
        ACCESS: begin
          // Both views of the read word are captured; only one is used.
          r_mem_wdata  <= w_merged;
          r_resp_rdata <= r_we ? 32'h0000_0000 : w_load_data;
        end
        RESP: begin
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0000_0000;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign mem_read   = w_mem_read;
  assign mem_write  = w_mem_write;
  assign mem_addr   = r_addr[6:2];
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:31];
  logic        tb_init;
  int          n_wr;
  int          n_rd;
  int          n_illegal;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(7)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  // Word memory plus strobe monitors.
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0000_0000;
      mem[1]       <= 32'h5566_7788;
      mem[4]       <= 32'h1122_3344;
      n_wr         <= 0;
      n_rd         <= 0;
      n_illegal    <= 0;
      last_wr_addr <= 5'd0;
      last_wr_data <= 32'h0;
    end else begin
      if (mem_write) begin
        mem[mem_addr] <= mem_wdata;
        n_wr          <= n_wr + 1;
        last_wr_addr  <= mem_addr;
        last_wr_data  <= mem_wdata;
      end
      if (mem_read) n_rd <= n_rd + 1;
      if ((mem_read && mem_write) || ((resp_valid || req_ready) && (mem_read || mem_write)))
        n_illegal <= n_illegal + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, wait for its response, return to IDLE.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [6:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      tick();
      lat++;
    end
    if (!resp_valid) lat = 0;
    rd  = resp_rdata;
    err = resp_err;
    tick();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  int          snap;
  logic [6:0]  b2b_addr [3] = '{7'h08, 7'h10, 7'h04};
  logic [31:0] b2b_exp  [3] = '{32'hDEAD_BEEF, 32'hBEEF_AA44, 32'h5566_7788};
  logic [31:0] got [3];
  int          acc_cyc [3];
  int          acc;
  int          nresp;
  int          extra;
  logic        will_acc;

  initial begin
    tb_init = 1'b1; RST = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 7'h00; req_wdata = 32'h0;
    tick();
    tick();
    chk("rst_ready",      {31'd0, req_ready},  32'd0);
    chk("rst_mem_read",   {31'd0, mem_read},   32'd0);
    chk("rst_mem_write",  {31'd0, mem_write},  32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    tb_init = 1'b0; RST = 1'b0;
    #1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Word store then word load at 0x08.
    do_req(1'b1, SZ_WORD, 1'b0, 7'h08, 32'hDEAD_BEEF, lat, rd, err);
    chk("sw_lat",     32'(lat),     32'd3);
    chk("sw_err",     {31'd0, err}, 32'd0);
    chk("sw_rdata",   rd,           32'd0);
    chk("sw_nwr",     32'(n_wr),    32'd1);
    chk("sw_wr_addr", {27'd0, last_wr_addr}, 32'd2);
    chk("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
    chk("sw_mem2",    mem[2],       32'hDEAD_BEEF);
    do_req(1'b0, SZ_WORD, 1'b0, 7'h08, 32'h0, lat, rd, err);
    chk("lw_lat",   32'(lat), 32'd2);
    chk("lw_rdata", rd,       32'hDEAD_BEEF);

    // Byte store into a preloaded word, then byte/half loads.
    do_req(1'b1, SZ_BYTE, 1'b0, 7'h11, 32'h1234_56AA, lat, rd, err);
    chk("sb_lat",  32'(lat), 32'd3);
    chk("sb_mem4", mem[4],   32'h1122_AA44);
    do_req(1'b0, SZ_BYTE, 1'b1, 7'h11, 32'h0, lat, rd, err);
    chk("lb_s",     rd,       32'hFFFF_FFAA);
    chk("lb_s_lat", 32'(lat), 32'd2);
    do_req(1'b0, SZ_BYTE, 1'b0, 7'h11, 32'h0, lat, rd, err);
    chk("lb_u", rd, 32'h0000_00AA);
    do_req(1'b0, SZ_HALF, 1'b1, 7'h10, 32'h0, lat, rd, err);
    chk("lh_s_lo", rd, 32'hFFFF_AA44);
    do_req(1'b0, SZ_HALF, 1'b1, 7'h12, 32'h0, lat, rd, err);
    chk("lh_s_hi", rd, 32'h0000_1122);

    // Half store into upper half, then byte loads from edge lanes.
    do_req(1'b1, SZ_HALF, 1'b0, 7'h12, 32'h1234_BEEF, lat, rd, err);
    chk("sh_mem4", mem[4], 32'hBEEF_AA44);
    do_req(1'b0, SZ_BYTE, 1'b0, 7'h13, 32'h0, lat, rd, err);
    chk("lb_u_l3", rd, 32'h0000_00BE);
    do_req(1'b0, SZ_BYTE, 1'b1, 7'h10, 32'h0, lat, rd, err);
    chk("lb_s_l0", rd, 32'h0000_0044);

    // Error requests: no memory access, one-cycle latency.
    snap = n_rd;
    do_req(1'b0, SZ_HALF, 1'b1, 7'h03, 32'h0, lat, rd, err);
    chk("mis_h_lat",   32'(lat),     32'd1);
    chk("mis_h_err",   {31'd0, err}, 32'd1);
    chk("mis_h_rdata", rd,           32'd0);
    chk("mis_h_nrd",   32'(n_rd),    32'(snap));
    snap = n_wr;
    do_req(1'b1, SZ_WORD, 1'b0, 7'h0A, 32'h0BAD_0BAD, lat, rd, err);
    chk("mis_w_err",  {31'd0, err}, 32'd1);
    chk("mis_w_nwr",  32'(n_wr),    32'(snap));
    chk("mis_w_mem2", mem[2],       32'hDEAD_BEEF);
    do_req(1'b0, SZ_ILL, 1'b0, 7'h00, 32'h0, lat, rd, err);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_lat", 32'(lat),     32'd1);

    // Reset landing in WRITE must not commit the store.
    snap = n_wr;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 7'h04; req_wdata = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wr_state_write", {31'd0, mem_write}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_wr_gate",  {31'd0, mem_write}, 32'd0);
    chk("rst_wr_ready", {31'd0, req_ready}, 32'd0);
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready},  32'd1);
    chk("post_rst_mem1",  mem[1],              32'h5566_7788);
    chk("post_rst_nwr",   32'(n_wr),           32'(snap));
    chk("post_rst_rv",    {31'd0, resp_valid}, 32'd0);

    // Three loads with req_valid held high.
    acc = 0; nresp = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = b2b_addr[0];
    snap = n_rd;
    for (int cyc = 0; cyc < 30 && nresp < 3; cyc++) begin
      will_acc = req_valid && req_ready;
      tick();
      if (resp_valid) begin
        if (nresp < 3) got[nresp] = resp_rdata;
        nresp++;
      end
      if (will_acc) begin
        if (acc < 3) acc_cyc[acc] = cyc;
        acc++;
        if (acc < 3) req_addr = b2b_addr[acc];
        else req_valid = 1'b0;
      end
    end
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (resp_valid) extra++;
    end
    chk("b2b_acc",   32'(acc),   32'd3);
    chk("b2b_nresp", 32'(nresp), 32'd3);
    chk("b2b_extra", 32'(extra), 32'd0);
    chk("b2b_nrd",   32'(n_rd - snap), 32'd3);
    for (int i = 0; i < 3; i++) chk("b2b_data", got[i], b2b_exp[i]);
    chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

    chk("strobe_rules", 32'(n_illegal), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
